id_pipe_stage: RTL and testbench

- Registered, handshaked successor to the combinational decode stage. Sits between IF and EX.
- Decodes one RISC-V instruction per cycle into a pipeline register: operands, ALU/branch one-hots, memory controls and jump immediate.
- Adds valid/ready flow control, flush, a one-cycle load-use bubble and illegal-instruction flagging.
- XLEN is a parameter: 32 gives RV32I, 64 gives RV64I with word ops.

---
 rtl/id_pipe_stage.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_id_pipe_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: registered RISC-V instruction decode stage between IF and EX.
// Decodes one instruction per cycle into a valid/ready pipeline register.
// It also provides flush, a one-cycle bubble after a load leaves, a load-use
// hazard stall, and illegal-instruction flagging.
// XLEN=32 gives RV32I. XLEN=64 gives RV64I, including the *W word ops.
module id_pipe_stage #(
  parameter int XLEN  = 64,
  parameter int ALU_W = 10,
  parameter int BJ_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  r_data1,
  input  logic [XLEN-1:0]  r_data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic [XLEN-1:0]  out_jmp_imm,
  output logic [ALU_W-1:0] out_alu_info,
  output logic [BJ_W-1:0]  out_bj_info,
  output logic [4:0]       out_rd_addr,
  output logic             out_rd_w_ena,
  output logic             out_mem_to_reg,
  output logic             out_mem_w_ena,
  output logic [2:0]       out_mem_func3,
  output logic             out_is_word,
  output logic             out_illegal
);

  localparam bit IS64 = (XLEN == 64);

  // ALU one-hot bit positions
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_XOR  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_AND  = 6;
  localparam int ALU_SLL  = 7;
  localparam int ALU_SRL  = 8;
  localparam int ALU_SRA  = 9;

  // branch/jump one-hot bit positions
  localparam int BJ_BEQ  = 0;
  localparam int BJ_BNE  = 1;
  localparam int BJ_BLT  = 2;
  localparam int BJ_BGE  = 3;
  localparam int BJ_BLTU = 4;
  localparam int BJ_BGEU = 5;
  localparam int BJ_JALR = 6;
  localparam int BJ_JAL  = 7;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0f;
  localparam logic [6:0] OPC_ARITHI = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_ARIWI  = 7'h1b;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_ARITH  = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_ARIW   = 7'h3b;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_SYS    = 7'h73;

  // Sign-extends a 32-bit value to XLEN; this works for both XLEN=32 and XLEN=64.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_off;
  logic            w_sll_ok;
  logic            w_srx_ok;

  assign w_opc   = in_inst[6:0];
  assign w_f3    = in_inst[14:12];
  assign w_f7    = in_inst[31:25];
  assign w_rd    = in_inst[11:7];
  assign w_imm_i = sext32({{20{in_inst[31]}}, in_inst[31:20]});
  assign w_imm_s = sext32({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
  assign w_imm_b = sext32({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0});
  assign w_imm_u = sext32({in_inst[31:12], 12'b0});
  assign w_imm_j = sext32({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0});

  // jalr offset: the aligned absolute target, rebased to pc
  assign w_jalr_sum = r_data1 + w_imm_i;
  assign w_jalr_off = {w_jalr_sum[XLEN-1:1], 1'b0} - in_pc;

  // Shift-immediate legality. On RV64 the shamt is 6 bits wide, so bit 25 is free.
  assign w_sll_ok = IS64 ? (in_inst[31:26] == 6'b000000) : (w_f7 == 7'h00);
  assign w_srx_ok = IS64 ? ((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000))
                         : ((w_f7 == 7'h00) || (w_f7 == 7'h20));

  logic [XLEN-1:0]  w_op1;
  logic [XLEN-1:0]  w_op2;
  logic [XLEN-1:0]  w_jmp;
  logic [ALU_W-1:0] w_alu;
  logic [BJ_W-1:0]  w_bj;
  logic             w_m2r;
  logic             w_mw;
  logic [2:0]       w_mf3;
  logic             w_word;
  logic             w_ill;
  logic             w_use1;
  logic             w_use2;
  logic             w_has_rd;
  logic             w_rd_w;

  // Decode in_inst into next-state values for the pipeline register.
  always_comb begin
    w_op1    = '0;
    w_op2    = '0;
    w_jmp    = '0;
    w_alu    = '0;
    w_bj     = '0;
    w_m2r    = 1'b0;
    w_mw     = 1'b0;
    w_mf3    = 3'b000;
    w_word   = 1'b0;
    w_ill    = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    w_has_rd = 1'b0;
    case (w_opc)
      OPC_LOAD: begin
        w_use1         = 1'b1;
        w_has_rd       = 1'b1;
        w_op1          = r_data1;
        w_op2          = w_imm_i;
        w_alu[ALU_ADD] = 1'b1;
        w_m2r          = 1'b1;
        w_mf3          = w_f3;
        w_ill          = (w_f3 == 3'd7) || (!IS64 && ((w_f3 == 3'd3) || (w_f3 == 3'd6)));
      end
      OPC_FENCE: begin
        w_use1 = 1'b1;
        w_op1  = r_data1;
        w_ill  = (w_f3 > 3'd1);
      end
      OPC_ARITHI: begin
        w_use1   = 1'b1;
        w_has_rd = 1'b1;
        w_op1    = r_data1;
        w_op2    = w_imm_i;
        case (w_f3)
          3'd0: w_alu[ALU_ADD]  = 1'b1;
          3'd1: begin
            w_alu[ALU_SLL] = 1'b1;
            w_ill          = ~w_sll_ok;
          end
          3'd2: w_alu[ALU_SLT]  = 1'b1;
          3'd3: w_alu[ALU_SLTU] = 1'b1;
          3'd4: w_alu[ALU_XOR]  = 1'b1;
          3'd5: begin
            if (in_inst[30]) w_alu[ALU_SRA] = 1'b1;
            else             w_alu[ALU_SRL] = 1'b1;
            w_ill = ~w_srx_ok;
          end
          3'd6: w_alu[ALU_OR]   = 1'b1;
          default: w_alu[ALU_AND] = 1'b1;
        endcase
      end
      OPC_ARIWI: begin
        w_use1   = 1'b1;
        w_has_rd = 1'b1;
        w_word   = IS64;
        w_op1    = r_data1;
        w_op2    = w_imm_i;
        case (w_f3)
          3'd0: w_alu[ALU_ADD] = 1'b1;
          3'd1: begin
            w_alu[ALU_SLL] = 1'b1;
            w_ill          = (w_f7 != 7'h00);
          end
          3'd5: begin
            if (in_inst[30]) w_alu[ALU_SRA] = 1'b1;
            else             w_alu[ALU_SRL] = 1'b1;
            w_ill = (w_f7 != 7'h00) && (w_f7 != 7'h20);
          end
          default: w_ill = 1'b1;
        endcase
        if (!IS64) w_ill = 1'b1;
      end
      OPC_AUIPC: begin
        w_has_rd       = 1'b1;
        w_op1          = in_pc;
        w_op2          = w_imm_u;
        w_alu[ALU_ADD] = 1'b1;
      end
      OPC_LUI: begin
        w_has_rd       = 1'b1;
        w_op2          = w_imm_u;
        w_alu[ALU_ADD] = 1'b1;
      end
      OPC_STORE: begin
        w_use1         = 1'b1;
        w_use2         = 1'b1;
        w_op1          = r_data1;
        w_op2          = w_imm_s;
        w_alu[ALU_ADD] = 1'b1;
        w_mw           = 1'b1;
        w_mf3          = w_f3;
        w_ill          = (w_f3 > 3'd3) || (!IS64 && (w_f3 == 3'd3));
      end
      OPC_ARITH: begin
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_has_rd = 1'b1;
        w_op1    = r_data1;
        w_op2    = r_data2;
        if (w_f7 == 7'h00) begin
          case (w_f3)
            3'd0: w_alu[ALU_ADD]  = 1'b1;
            3'd1: w_alu[ALU_SLL]  = 1'b1;
            3'd2: w_alu[ALU_SLT]  = 1'b1;
            3'd3: w_alu[ALU_SLTU] = 1'b1;
            3'd4: w_alu[ALU_XOR]  = 1'b1;
            3'd5: w_alu[ALU_SRL]  = 1'b1;
            3'd6: w_alu[ALU_OR]   = 1'b1;
            default: w_alu[ALU_AND] = 1'b1;
          endcase
        end else if ((w_f7 == 7'h20) && (w_f3 == 3'd0)) begin
          w_alu[ALU_SUB] = 1'b1;
        end else if ((w_f7 == 7'h20) && (w_f3 == 3'd5)) begin
          w_alu[ALU_SRA] = 1'b1;
        end else begin
          w_ill = 1'b1;
        end
      end
      OPC_ARIW: begin
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_has_rd = 1'b1;
        w_word   = IS64;
        w_op1    = r_data1;
        w_op2    = r_data2;
        if      ((w_f7 == 7'h00) && (w_f3 == 3'd0)) w_alu[ALU_ADD] = 1'b1;
        else if ((w_f7 == 7'h00) && (w_f3 == 3'd1)) w_alu[ALU_SLL] = 1'b1;
        else if ((w_f7 == 7'h00) && (w_f3 == 3'd5)) w_alu[ALU_SRL] = 1'b1;
        else if ((w_f7 == 7'h20) && (w_f3 == 3'd0)) w_alu[ALU_SUB] = 1'b1;
        else if ((w_f7 == 7'h20) && (w_f3 == 3'd5)) w_alu[ALU_SRA] = 1'b1;
        else                                        w_ill          = 1'b1;
        if (!IS64) w_ill = 1'b1;
      end
      OPC_BRANCH: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_op1  = r_data1;
        w_op2  = r_data2;
        w_jmp  = w_imm_b;
        case (w_f3)
          3'd0: w_bj[BJ_BEQ]  = 1'b1;
          3'd1: w_bj[BJ_BNE]  = 1'b1;
          3'd4: w_bj[BJ_BLT]  = 1'b1;
          3'd5: w_bj[BJ_BGE]  = 1'b1;
          3'd6: w_bj[BJ_BLTU] = 1'b1;
          3'd7: w_bj[BJ_BGEU] = 1'b1;
          default: w_ill = 1'b1;
        endcase
      end
      OPC_JALR: begin
        w_use1         = 1'b1;
        w_has_rd       = 1'b1;
        w_op1          = in_pc;
        w_op2          = XLEN'(4);
        w_jmp          = w_jalr_off;
        w_alu[ALU_ADD] = 1'b1;
        w_bj[BJ_JALR]  = 1'b1;
        w_ill          = (w_f3 != 3'd0);
      end
      OPC_JAL: begin
        w_has_rd       = 1'b1;
        w_op1          = in_pc;
        w_op2          = XLEN'(4);
        w_jmp          = w_imm_j;
        w_alu[ALU_ADD] = 1'b1;
        w_bj[BJ_JAL]   = 1'b1;
      end
      OPC_SYS: begin
        w_op1 = r_data1;
        // The csr immediate forms (func3 5..7) reuse the rs1 field as zimm.
        w_use1   = (w_f3 == 3'd1) || (w_f3 == 3'd2) || (w_f3 == 3'd3);
        w_has_rd = (w_f3 != 3'd0) && (w_f3 != 3'd4);
        w_ill    = (w_f3 == 3'd4);
      end
      default: w_ill = 1'b1;
    endcase
    // An illegal instruction still flows down the pipe, but it must cause no side effects.
    if (w_ill) begin
      w_alu  = '0;
      w_bj   = '0;
      w_m2r  = 1'b0;
      w_mw   = 1'b0;
      w_word = 1'b0;
    end
  end

  assign w_rd_w   = w_has_rd & (w_rd != 5'd0) & ~w_ill;
  assign rs1_addr = w_use1 ? in_inst[19:15] : 5'd0;
  assign rs2_addr = w_use2 ? in_inst[24:20] : 5'd0;

  logic             r_valid;
  logic             r_bubble;
  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  r_op1;
  logic [XLEN-1:0]  r_op2;
  logic [XLEN-1:0]  r_jmp;
  logic [ALU_W-1:0] r_alu;
  logic [BJ_W-1:0]  r_bj;
  logic [4:0]       r_rd;
  logic             r_rd_w;
  logic             r_m2r;
  logic             r_mw;
  logic [2:0]       r_mf3;
  logic             r_word;
  logic             r_ill;
  logic             w_hazard;
  logic             w_accept;

  // An unused rs reads as x0. r_rd_w already implies rd != 0, so x0 never hazards.
  assign w_hazard = r_valid & r_m2r & r_rd_w &
                    ((rs1_addr == r_rd) | (rs2_addr == r_rd));
  assign in_ready = rst & ~flush & ~r_bubble & ~w_hazard & (~r_valid | out_ready);
  assign w_accept = in_valid & in_ready;

  // Pipeline register: reset, flush, accept-and-load, or drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_bubble <= 1'b0;
      r_pc     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_jmp    <= '0;
      r_alu    <= '0;
      r_bj     <= '0;
      r_rd     <= 5'd0;
      r_rd_w   <= 1'b0;
      r_m2r    <= 1'b0;
      r_mw     <= 1'b0;
      r_mf3    <= 3'b000;
      r_word   <= 1'b0;
      r_ill    <= 1'b0;
    end else if (flush) begin
      r_valid  <= 1'b0;
      r_bubble <= 1'b0;
    end else begin
      r_bubble <= r_valid & out_ready & r_m2r & r_rd_w;
      if (w_accept) begin
        r_valid <= 1'b1;
        r_pc    <= in_pc;
        r_op1   <= w_op1;
        r_op2   <= w_op2;
        r_jmp   <= w_jmp;
        r_alu   <= w_alu;
        r_bj    <= w_bj;
        r_rd    <= w_has_rd ? w_rd : 5'd0;
        r_rd_w  <= w_rd_w;
        r_m2r   <= w_m2r;
        r_mw    <= w_mw;
        r_mf3   <= w_mf3;
        r_word  <= w_word;
        r_ill   <= w_ill;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_valid;
  assign out_pc         = r_pc;
  assign out_op1        = r_op1;
  assign out_op2        = r_op2;
  assign out_jmp_imm    = r_jmp;
  assign out_alu_info   = r_alu;
  assign out_bj_info    = r_bj;
  assign out_rd_addr    = r_rd;
  assign out_rd_w_ena   = r_rd_w;
  assign out_mem_to_reg = r_m2r;
  assign out_mem_w_ena  = r_mw;
  assign out_mem_func3  = r_mf3;
  assign out_is_word    = r_word;
  assign out_illegal    = r_ill;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed bench for id_pipe_stage: one XLEN=64 instance and one XLEN=32 instance.
module tb_id_pipe_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_ready, out_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc, r_data1, r_data2;
  logic [4:0]  rs1_addr, rs2_addr, out_rd_addr;
  logic [63:0] out_pc, out_op1, out_op2, out_jmp_imm;
  logic [9:0]  out_alu_info;
  logic [7:0]  out_bj_info;
  logic        out_rd_w_ena, out_mem_to_reg, out_mem_w_ena, out_is_word, out_illegal;
  logic [2:0]  out_mem_func3;

  logic        in_valid32, in_ready32, out_ready32, out_valid32;
  logic [31:0] in_inst32, in_pc32, r_data1_32, r_data2_32;
  logic [4:0]  rs1_addr32, rs2_addr32, out_rd_addr32;
  logic [31:0] out_pc32, out_op1_32, out_op2_32, out_jmp_imm32;
  logic [9:0]  out_alu_info32;
  logic [7:0]  out_bj_info32;
  logic        out_rd_w_ena32, out_mem_to_reg32, out_mem_w_ena32, out_is_word32, out_illegal32;
  logic [2:0]  out_mem_func3_32;

  // Register file model: xN reads 0x1000 + N, and x0 reads 0.
  function automatic logic [63:0] rfv(input logic [4:0] a);
    return (a == 5'd0) ? 64'd0 : 64'h1000 + 64'(a);
  endfunction

  assign r_data1    = rfv(rs1_addr);
  assign r_data2    = rfv(rs2_addr);
  assign r_data1_32 = 32'(rfv(rs1_addr32));
  assign r_data2_32 = 32'(rfv(rs2_addr32));

  id_pipe_stage #(.XLEN(64)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .r_data1(r_data1), .r_data2(r_data2), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2), .out_jmp_imm(out_jmp_imm),
    .out_alu_info(out_alu_info), .out_bj_info(out_bj_info), .out_rd_addr(out_rd_addr),
    .out_rd_w_ena(out_rd_w_ena), .out_mem_to_reg(out_mem_to_reg),
    .out_mem_w_ena(out_mem_w_ena), .out_mem_func3(out_mem_func3),
    .out_is_word(out_is_word), .out_illegal(out_illegal));

  id_pipe_stage #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_inst(in_inst32), .in_pc(in_pc32), .rs1_addr(rs1_addr32), .rs2_addr(rs2_addr32),
    .r_data1(r_data1_32), .r_data2(r_data2_32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_pc(out_pc32), .out_op1(out_op1_32), .out_op2(out_op2_32),
    .out_jmp_imm(out_jmp_imm32), .out_alu_info(out_alu_info32),
    .out_bj_info(out_bj_info32), .out_rd_addr(out_rd_addr32),
    .out_rd_w_ena(out_rd_w_ena32), .out_mem_to_reg(out_mem_to_reg32),
    .out_mem_w_ena(out_mem_w_ena32), .out_mem_func3(out_mem_func3_32),
    .out_is_word(out_is_word32), .out_illegal(out_illegal32));

  localparam logic [31:0] I_ADDI_M1 = 32'hfff00293; // addi x5,x0,-1
  localparam logic [31:0] I_ADD_IND = 32'h002403b3; // add x7,x8,x2
  localparam logic [31:0] I_ADD_DEP = 32'h002303b3; // add x7,x6,x2
  localparam logic [31:0] I_LD      = 32'h0000b303; // ld x6,0(x1)
  localparam logic [31:0] I_ADDW    = 32'h007302bb; // addw x5,x6,x7

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc, op1, op2, jmp;
    logic [9:0]  alu;
    logic [7:0]  bj;
    logic [4:0]  rd;
    logic        rdw, ill, word, mw, c_ops, c_jmp, c_alu;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //          inst          pc              op1          op2                    jmp                    alu     bj     rd  rdw ill wd mw ops jmp alu
    vecs[0] = '{32'h002403b3, 64'h80000004, 64'h1008, 64'h1002,            64'h0,                 10'h001, 8'h00, 7,  1, 0, 0, 0, 1, 0, 1}; // add x7,x8,x2
    vecs[1] = '{32'h403100b3, 64'h80000008, 64'h1002, 64'h1003,            64'h0,                 10'h002, 8'h00, 1,  1, 0, 0, 0, 1, 0, 1}; // sub x1,x2,x3
    vecs[2] = '{32'h12345537, 64'h8000000c, 64'h0,    64'h12345000,        64'h0,                 10'h001, 8'h00, 10, 1, 0, 0, 0, 1, 0, 1}; // lui x10,0x12345
    vecs[3] = '{32'hfe208ee3, 64'h80000010, 64'h1001, 64'h1002,            64'hfffffffffffffffc,  10'h000, 8'h01, 0,  0, 0, 0, 0, 1, 1, 0}; // beq x1,x2,-4
    vecs[4] = '{32'h0020a423, 64'h80000014, 64'h1001, 64'h8,               64'h0,                 10'h001, 8'h00, 0,  0, 0, 0, 1, 1, 0, 1}; // sw x2,8(x1)
    vecs[5] = '{32'h008180e7, 64'h1000,     64'h1000, 64'h4,               64'ha,                 10'h001, 8'h40, 1,  1, 0, 0, 0, 1, 1, 1}; // jalr x1,8(x3)
    vecs[6] = '{32'h007302bb, 64'h1004,     64'h1006, 64'h1007,            64'h0,                 10'h001, 8'h00, 5,  1, 0, 1, 0, 1, 0, 1}; // addw x5,x6,x7
    vecs[7] = '{32'h00000000, 64'h1008,     64'h0,    64'h0,               64'h0,                 10'h000, 8'h00, 0,  0, 1, 0, 0, 0, 0, 1}; // unknown opcode
    vecs[8] = '{32'h00000013, 64'h100c,     64'h0,    64'h0,               64'h0,                 10'h001, 8'h00, 0,  0, 0, 0, 0, 1, 0, 1}; // addi x0,x0,0

    // reset with in_valid held high
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_inst = I_ADDI_M1; in_pc = 64'h80000000;
    out_ready = 1'b1;
    in_valid32 = 1'b1; out_ready32 = 1'b1; in_inst32 = I_ADDW; in_pc32 = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
    end
    chk("rst_op2", out_op2, 64'd0);
    chk("rst_in_ready32", 64'(in_ready32), 64'd0);

    rst = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_op2", out_op2, 64'hffffffffffffffff);
    chk("addi_op1", out_op1, 64'd0);
    chk("addi_rd", 64'(out_rd_addr), 64'd5);
    chk("addi_alu", 64'(out_alu_info), 64'h001);
    chk("addi_rdw", 64'(out_rd_w_ena), 64'd1);
    chk("addi_pc", out_pc, 64'h80000000);
    chk("x32_addw_ill", 64'(out_illegal32), 64'd1);
    chk("x32_addw_rdw", 64'(out_rd_w_ena32), 64'd0);
    chk("x32_addw_word", 64'(out_is_word32), 64'd0);
    chk("x32_addw_valid", 64'(out_valid32), 64'd1);

    // back-pressure: the register must hold, while the 32-bit instance keeps decoding
    out_ready = 1'b0; in_inst = I_ADD_IND; in_pc = 64'h80000004;
    in_inst32 = I_LD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_op2", out_op2, 64'hffffffffffffffff);
      chk("bp_rd", 64'(out_rd_addr), 64'd5);
      chk("bp_pc", out_pc, 64'h80000000);
      if (i == 0) begin
        chk("x32_ld_ill", 64'(out_illegal32), 64'd1);
        chk("x32_ld_m2r", 64'(out_mem_to_reg32), 64'd0);
        in_inst32 = I_ADDI_M1;
      end else if (i == 1) begin
        chk("x32_addi_ill", 64'(out_illegal32), 64'd0);
        chk("x32_addi_op2", 64'(out_op2_32), 64'hffffffff);
        in_valid32 = 1'b0;
      end
    end

    // back-to-back stream at one instruction per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_inst = vecs[i].inst; in_pc = vecs[i].pc;
      #1;
      chk($sformatf("s%0d_in_ready", i), 64'(in_ready), 64'd1);
      tick();
      chk($sformatf("s%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("s%0d_pc", i), out_pc, vecs[i].pc);
      chk($sformatf("s%0d_ill", i), 64'(out_illegal), 64'(vecs[i].ill));
      chk($sformatf("s%0d_rdw", i), 64'(out_rd_w_ena), 64'(vecs[i].rdw));
      chk($sformatf("s%0d_bj", i), 64'(out_bj_info), 64'(vecs[i].bj));
      chk($sformatf("s%0d_mw", i), 64'(out_mem_w_ena), 64'(vecs[i].mw));
      chk($sformatf("s%0d_word", i), 64'(out_is_word), 64'(vecs[i].word));
      if (vecs[i].rdw) chk($sformatf("s%0d_rd", i), 64'(out_rd_addr), 64'(vecs[i].rd));
      if (vecs[i].c_alu) chk($sformatf("s%0d_alu", i), 64'(out_alu_info), 64'(vecs[i].alu));
      if (vecs[i].c_jmp) chk($sformatf("s%0d_jmp", i), out_jmp_imm, vecs[i].jmp);
      if (vecs[i].c_ops) begin
        chk($sformatf("s%0d_op1", i), out_op1, vecs[i].op1);
        chk($sformatf("s%0d_op2", i), out_op2, vecs[i].op2);
      end
    end

    // load-use: dependent add waits for the hazard, then the bubble
    in_inst = I_LD; in_pc = 64'h2000;
    #1;
    chk("lu_ld_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("lu_ld_m2r", 64'(out_mem_to_reg), 64'd1);
    chk("lu_ld_rd", 64'(out_rd_addr), 64'd6);
    chk("lu_ld_f3", 64'(out_mem_func3), 64'd3);
    chk("lu_ld_op1", out_op1, 64'h1001);
    in_inst = I_ADD_DEP; in_pc = 64'h2004;
    #1;
    chk("lu_rs1", 64'(rs1_addr), 64'd6);
    chk("lu_hazard_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu_idle_valid", 64'(out_valid), 64'd0);
    chk("lu_bubble_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu_post_ready", 64'(in_ready), 64'd1);
    tick();
    chk("lu_add_valid", 64'(out_valid), 64'd1);
    chk("lu_add_rd", 64'(out_rd_addr), 64'd7);
    chk("lu_add_op1", out_op1, 64'h1006);

    // independent add follows the load with no gap
    in_inst = I_LD; in_pc = 64'h3000;
    #1;
    chk("ind_ld_ready", 64'(in_ready), 64'd1);
    tick();
    in_inst = I_ADD_IND; in_pc = 64'h3004;
    #1;
    chk("ind_add_ready", 64'(in_ready), 64'd1);
    tick();
    chk("ind_add_valid", 64'(out_valid), 64'd1);
    chk("ind_add_pc", out_pc, 64'h3004);
    chk("ind_bubble_ready", 64'(in_ready), 64'd0);
    tick();
    chk("ind_drain_valid", 64'(out_valid), 64'd0);

    // flush while a load sits in the register: no bubble afterwards
    in_inst = I_LD; in_pc = 64'h4000;
    #1;
    chk("fl_ld_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_ld_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; in_inst = I_ADD_IND; in_pc = 64'h4004;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    #1;
    chk("fl_post_ready", 64'(in_ready), 64'd1);
    tick();
    chk("fl_add_valid", 64'(out_valid), 64'd1);
    chk("fl_add_pc", out_pc, 64'h4004);
    in_valid = 1'b0;
    tick();
    chk("end_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
